sbox_lane_array: RTL and testbench
==================================

Name: sbox_lane_array

Overview:
- Pipelined, multi-lane AES byte-substitution unit.
- Applies the FIPS-197 S-box (encrypt) or inverse S-box (decrypt) to LANES bytes per beat; the mode is selected per beat.
- Valid/ready handshake on input and output, with a sideband tag carried alongside each beat.
- Sits between the round-state register and ShiftRows/MixColumns in the round datapath; LANES=4 serves key expansion (SubWord), LANES=16 serves a full-state SubBytes.

Parameters:
- LANES, 16, number of byte lanes processed per beat (1..16).
- LATENCY, 2, register stages from input acceptance to output valid (1..3).
- TAG_W, 4, width of the sideband tag passed through unchanged (>=1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box, for this beat.
- in_data  in  8*LANES  input bytes; lane i = in_data[8i+7:8i].
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  8*LANES  substituted bytes, same lane order as input.
- out_tag  out  TAG_W  tag of the beat on out_data.
- out_inv  out  1  mode used for the beat on out_data.
- busy  out  1  one or more beats held in the pipeline.

Behaviour:
- Reset: every stage valid bit is cleared. out_valid=0, busy=0, out_data=0, out_tag=0, out_inv=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats; no partial beat is ever emitted afterwards.
- Substitution:
  - Per lane, out byte = SBOX[in] when inv=0, INV_SBOX[in] when inv=1.
  - Lanes are independent; no cross-lane mixing.
  - Both tables are the full 256-entry FIPS-197 tables; no undefined entries. Every case/lookup has a default of 8'h00 (unreachable).
- Pipeline:
  - LATENCY stages, each holding {valid, inv, tag, data}.
  - Table lookup is combinational ahead of stage 1; later stages are pure registers.
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational from out_valid/out_ready; no combinational path from in_valid).
  - On a cycle with adv=1, every stage loads from its predecessor, and stage 1 loads {in_valid, lookup(in_data, in_inv), in_tag}.
  - On a cycle with adv=0, all stages hold.
  - Input accepted iff in_valid && in_ready. Output consumed iff out_valid && out_ready.
  - Latency: a beat accepted at edge N appears with out_valid=1 after edge N+LATENCY-1 (i.e. visible in the cycle following edge N+LATENCY-1), provided adv stays 1.
  - Throughput: one beat per cycle while out_ready=1; bubbles (in_valid=0) propagate as invalid stages.
- Ordering: beats exit in acceptance order, with their own inv and tag; no drops, no duplicates.
- Backpressure: while out_valid=1 and out_ready=0, out_data/out_tag/out_inv are stable and in_ready=0.
- Simultaneous events: when the output is consumed and a new input is accepted in the same cycle, both take effect.
- Mode switch: alternating in_inv on consecutive beats needs no bubble.
- busy = OR of all stage valid bits.
- Boundary cases:
  - LATENCY=1 gives a single output register.
  - LANES=1 gives an 8-bit datapath.
  - Values of LATENCY outside 1..3 are a parameter error, flagged by an elaboration-time check.

Test Plan:
- Fwd single lane, LANES=16, LATENCY=2: in_data lane0=0x00, lane1=0x53, lane2=0xFF, rest 0x01, tag=0x5 -> after 2 cycles, lanes 0x63, 0xED, 0x16, rest 0x7C; out_tag=0x5.
- Inverse: same beat with in_inv=1, lanes 0x63, 0xED, 0x16 -> lanes 0x00, 0x53, 0xFF; out_inv=1.
- Exhaustive round-trip: stream all 256 byte values (replicated across lanes), alternating inv per beat, out_ready=1, then feed each forward result back with inv=1 -> original byte returned; 1 beat/cycle sustained.
- Backpressure: 5 back-to-back beats with tags 1..5, hold out_ready=0 for 4 cycles after the first output -> in_ready=0 throughout the stall, output frozen on tag 1; on release, tags 1..5 in order, none lost.
- Reset mid-flight: assert rst with 2 beats in the pipe -> next cycle out_valid=0, busy=0, in_ready=1; a subsequent beat 0x11 (fwd) -> 0x82 with correct latency.
- Parameter sweep: LANES=4/LATENCY=1 with in_data=0x00112233 fwd -> 0x638293C3 one cycle after acceptance.

Source files
------------

// File: rtl/sbox_lane_array.sv
// Pipelined multi-lane AES SubBytes / InvSubBytes with valid/ready handshake and a sideband tag.
// The table lookup sits ahead of stage 1; the remaining stages are plain registers that advance together.
module sbox_lane_array #(
  parameter int LANES   = 16,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_inv,
  output logic                 busy
);

  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("sbox_lane_array: LATENCY must be in 1..3");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("sbox_lane_array: LANES must be in 1..16");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef struct packed {
    logic               valid;
    logic               inv;
    logic [TAG_W-1:0]   tag;
    logic [8*LANES-1:0] data;
  } stage_t;

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [7:0] r;
    case (inv)
      1'b0:    r = SBOX[b];
      1'b1:    r = INV_SBOX[b];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  stage_t             pipe [LATENCY];
  logic [8*LANES-1:0] lookup;
  logic               adv;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    lookup = '0;
    for (int i = 0; i < LANES; i++) begin
      lookup[8*i +: 8] = sub_byte(in_data[8*i +: 8], in_inv);
    end
  end

  // The whole pipe moves as one: a stalled output freezes every stage, so no per-stage ready logic.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // NOTE: payload registers are cleared along with the valid bits so out_data/out_tag/out_inv read 0
  // after reset; sequential state uses non-blocking assignments so stage i sees stage i-1's old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else if (adv) begin
      pipe[0] <= '{valid: in_valid, inv: in_inv, tag: in_tag, data: lookup};
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign out_valid = pipe[LATENCY-1].valid;
  assign out_data  = pipe[LATENCY-1].data;
  assign out_tag   = pipe[LATENCY-1].tag;
  assign out_inv   = pipe[LATENCY-1].inv;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy = busy | pipe[i].valid;
    end
  end

endmodule

// File: tb/tb_sbox_lane_array.sv
// Directed bench for sbox_lane_array: a 16-lane/2-stage instance plus a 4-lane/1-stage instance.
module tb_sbox_lane_array;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_inv, out_ready;
  logic [127:0] in_data;
  logic [3:0]   in_tag;
  logic         in_ready, out_valid, out_inv, busy;
  logic [127:0] out_data;
  logic [3:0]   out_tag;

  logic         s4_in_valid, s4_in_inv, s4_in_ready, s4_out_valid, s4_out_inv, s4_busy;
  logic [31:0]  s4_in_data, s4_out_data;
  logic [3:0]   s4_in_tag, s4_out_tag;

  always #5 clk = ~clk;

  sbox_lane_array #(.LANES(16), .LATENCY(2), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_inv(out_inv), .busy(busy)
  );

  sbox_lane_array #(.LANES(4), .LATENCY(1), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_inv(s4_in_inv), .in_data(s4_in_data),
    .in_tag(s4_in_tag), .out_valid(s4_out_valid), .out_ready(1'b1), .out_data(s4_out_data),
    .out_tag(s4_out_tag), .out_inv(s4_out_inv), .busy(s4_busy)
  );

  typedef struct {
    logic [127:0] data;
    logic [3:0]   tag;
    logic         inv;
  } beat_t;

  beat_t        outq[$];
  beat_t        pass1[$];
  int           checks   = 0;
  int           failures = 0;
  logic         acc;
  logic [7:0]   bp_in  [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0]   bp_exp [5] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2};

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Settle, record handshake outcomes for the coming edge, then step to 1 time unit past it.
  task automatic tick(output logic accepted);
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) outq.push_back('{data: out_data, tag: out_tag, inv: out_inv});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx, stall, seen, first, last, nacc, sz;
    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    s4_in_valid = 1'b0; s4_in_inv = 1'b0; s4_in_data = '0; s4_in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_inv", out_inv, 0);

    // Forward lookup with 2-stage latency
    in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'h5;
    in_data = {{13{8'h01}}, 8'hFF, 8'h53, 8'h00};
    tick(acc);
    check("fwd_accept", acc, 1);
    in_valid = 1'b0;
    check("fwd_not_early", out_valid, 0);
    tick(acc);
    check("fwd_valid", out_valid, 1);
    check("fwd_data", out_data, {{13{8'h7C}}, 8'h16, 8'hED, 8'h63});
    check("fwd_tag", out_tag, 4'h5);
    check("fwd_inv", out_inv, 0);
    tick(acc);
    check("fwd_drained", busy, 0);

    // Inverse lookup
    in_valid = 1'b1; in_inv = 1'b1; in_tag = 4'hA;
    in_data = {{13{8'h7C}}, 8'h16, 8'hED, 8'h63};
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    check("inv_valid", out_valid, 1);
    check("inv_data", out_data, {{13{8'h01}}, 8'hFF, 8'h53, 8'h00});
    check("inv_tag", out_tag, 4'hA);
    check("inv_out_inv", out_inv, 1);
    tick(acc);

    // Four-lane, single-stage instance: output right after the accepting edge
    s4_in_valid = 1'b1; s4_in_inv = 1'b0; s4_in_tag = 4'h9; s4_in_data = 32'h00112233;
    #1;
    check("s4_in_ready", s4_in_ready, 1);
    @(posedge clk);
    #1;
    s4_in_inv = 1'b1; s4_in_tag = 4'h3; s4_in_data = 32'h638293C3;
    check("s4_fwd_valid", s4_out_valid, 1);
    check("s4_fwd_data", s4_out_data, 32'h638293C3);
    check("s4_fwd_tag", s4_out_tag, 4'h9);
    @(posedge clk);
    #1;
    s4_in_valid = 1'b0;
    check("s4_inv_data", s4_out_data, 32'h00112233);
    check("s4_inv_mode", s4_out_inv, 1);
    @(posedge clk);
    #1;
    check("s4_idle", s4_out_valid, 0);

    // Round trip over all byte values, alternating mode every beat, then each result fed back inverted
    outq.delete();
    first = -1; last = -1; nacc = 0;
    for (int c = 0; c < 260; c++) begin
      if (c < 256) begin
        in_valid = 1'b1; in_data = {16{c[7:0]}}; in_inv = c[0]; in_tag = c[3:0];
      end else begin
        in_valid = 1'b0;
      end
      sz = outq.size();
      tick(acc);
      if (acc) nacc++;
      if (outq.size() > sz) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    check("rt1_accepted", nacc, 256);
    check("rt1_count", outq.size(), 256);
    check("rt1_streak", last - first, 255);
    pass1 = outq;
    for (int i = 0; i < pass1.size(); i++) begin
      check("rt1_tag_inv", {pass1[i].inv, pass1[i].tag}, {i[0], i[3:0]});
    end
    outq.delete();
    for (int c = 0; c < 260; c++) begin
      if (c < pass1.size()) begin
        in_valid = 1'b1; in_data = pass1[c].data; in_inv = ~pass1[c].inv; in_tag = pass1[c].tag;
      end else begin
        in_valid = 1'b0;
      end
      tick(acc);
    end
    check("rt2_count", outq.size(), 256);
    for (int i = 0; i < outq.size(); i++) begin
      check("rt2_data", outq[i].data, {16{i[7:0]}});
    end

    // Backpressure: five beats, output stalled for four cycles on the first one
    outq.delete();
    idx = 0; stall = 0; seen = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (idx < 5);
      in_data  = (idx < 5) ? {16{bp_in[idx]}} : '0;
      in_tag   = 4'(idx + 1);
      in_inv   = 1'b0;
      if (out_valid && seen == 0) begin
        seen = 1;
        stall = 4;
      end
      out_ready = (stall == 0);
      if (stall > 0) begin
        #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_tag", out_tag, 4'h1);
        check("bp_hold_data", out_data, {16{8'h63}});
        stall--;
      end
      tick(acc);
      if (acc) idx++;
    end
    out_ready = 1'b1;
    check("bp_seen", seen, 1);
    check("bp_count", outq.size(), 5);
    for (int i = 0; i < outq.size() && i < 5; i++) begin
      check("bp_tag", outq[i].tag, 4'(i + 1));
      check("bp_data", outq[i].data, {16{bp_exp[i]}});
    end

    // Reset with two beats in flight
    in_valid = 1'b1; in_inv = 1'b0; in_data = {16{8'hAA}}; in_tag = 4'h7;
    tick(acc);
    in_tag = 4'h8;
    tick(acc);
    check("mid_busy", busy, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    check("mid_out_valid", out_valid, 0);
    check("mid_busy_clr", busy, 0);
    check("mid_in_ready", in_ready, 1);
    outq.delete();
    in_valid = 1'b1; in_inv = 1'b0; in_data = {16{8'h11}}; in_tag = 4'h3;
    tick(acc);
    in_valid = 1'b0;
    check("post_not_early", out_valid, 0);
    tick(acc);
    check("post_valid", out_valid, 1);
    check("post_data", out_data, {16{8'h82}});
    check("post_tag", out_tag, 4'h3);
    repeat (4) tick(acc);
    check("post_count", outq.size(), 1);
    check("post_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
